// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Brief  : Opcode, width and fetch-FSM constants shared by the fetch path.
// Rev    : 1.0
// ============================================================================
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_LW    = 6'h23;
  localparam logic [5:0]  OP_SW    = 6'h2B;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam int          INSTR_W  = 32;
  localparam logic [31:0] PC_INC   = 32'd4;

  localparam logic [0:0] c_st_fetch  = 1'b0;
  localparam logic [0:0] c_st_squash = 1'b1;

  // Wraps 32'hFFFF_FFFC to 0 by plain modulo-2^32 addition.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Brief  : Issue buffer of {pc,word} entries with push/pop/flush and count.
// Rev    : 1.0
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_cw'(DEPTH));
  assign w_pop   = pop & ~w_empty & ~flush;
  // A pop in the same cycle frees the slot a full-buffer push lands in.
  assign w_push  = push & (~w_full | w_pop) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch
// Brief  : PC owner and instruction fetcher with redirect/squash, feeding decode.
// Rev    : 1.0
// ============================================================================
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

  logic [0:0]      r_state;
  logic [0:0]      w_next_state;
  logic [31:0]     r_pc;
  logic [31:0]     r_saved_pc;
  logic            r_misalign;
  logic [c_cw-1:0] w_count;
  logic [63:0]     w_head;
  logic            w_empty;
  logic            w_pop;
  logic            w_slot_ok;
  logic            w_req;
  logic            w_ack;
  logic            w_outstanding;
  logic            w_push;
  logic [31:0]     w_redirect_pc;

  assign w_empty       = (w_count == '0);
  assign w_pop         = ~w_empty & instr_ready;
  assign w_slot_ok     = (w_count != c_cw'(FIFO_DEPTH)) | w_pop;
  assign w_ack         = imem_ack & w_req;
  assign w_outstanding = w_req & ~imem_ack;
  assign w_push        = (r_state == c_st_fetch) & w_ack & ~redirect;
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_st_fetch;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_fetch:  if (redirect && w_outstanding) w_next_state = c_st_squash;
      c_st_squash: if (w_ack) w_next_state = c_st_fetch;
      default:     w_next_state = c_st_fetch;
    endcase
  end

  // The squashed request must stay up until its ack even with no free slot.
  always_comb begin
    w_req = 1'b0;
    if (!reset) begin
      case (r_state)
        c_st_fetch:  w_req = w_slot_ok;
        c_st_squash: w_req = 1'b1;
        default:     w_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_saved_pc <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      if (redirect) r_saved_pc <= w_redirect_pc;
      if (redirect && (redirect_pc[1:0] != 2'b00)) r_misalign <= 1'b1;
      if (r_state == c_st_fetch) begin
        if (redirect) begin
          if (!w_outstanding) r_pc <= w_redirect_pc;
        end else if (w_ack) begin
          r_pc <= next_pc(r_pc);
        end
      end else if (w_ack) begin
        r_pc <= redirect ? w_redirect_pc : r_saved_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (w_push),
    .push_data ({r_pc, imem_rdata}),
    .pop       (w_pop),
    .flush     (redirect),
    .head_data (w_head),
    .count     (w_count)
  );

  assign imem_req     = w_req;
  assign imem_addr    = r_pc;
  assign instr_valid  = ~w_empty;
  assign instr_word   = w_head[INSTR_W-1:0];
  assign instr_pc     = w_head[63:32];
  assign opcode       = w_head[31:26];
  assign misalign_err = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch
// Brief  : Directed vectors and corner sequences for instr_fetch.
// Rev    : 1.0
// ============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ack, instr_valid, instr_ready, redirect, misalign_err;
  logic [31:0] imem_addr, imem_rdata, instr_word, instr_pc, redirect_pc;
  logic [5:0]  opcode;

  logic        req5, valid5, mis5;
  logic [31:0] addr5, rdata5, word5, pc5;
  logic [5:0]  op5;

  int delay = 0;
  int wcnt  = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        exp_valid;
    logic [5:0]  exp_op;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h8C01_0004;
    else if (a == 32'h4) return 32'hAC01_0008;
    else                 return 32'h1000_0000 | a;
  endfunction

  assign imem_ack   = imem_req && (wcnt >= delay);
  assign imem_rdata = mem_word(imem_addr);
  assign rdata5     = mem_word(addr5);

  always @(posedge clk) begin
    if (reset)                    wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else                          wcnt <= 0;
  end

  instr_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_word(instr_word), .instr_pc(instr_pc),
    .opcode(opcode), .redirect(redirect), .redirect_pc(redirect_pc),
    .misalign_err(misalign_err)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut5 (
    .clk(clk), .reset(reset), .imem_req(req5), .imem_addr(addr5),
    .imem_ack(req5), .imem_rdata(rdata5), .instr_valid(valid5),
    .instr_ready(1'b1), .instr_word(word5), .instr_pc(pc5),
    .opcode(op5), .redirect(1'b0), .redirect_pc(32'h0),
    .misalign_err(mis5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input logic r, input logic rdy, input logic v, input logic [5:0] op,
                     input logic [31:0] pc, input logic rq, input logic [31:0] ad);
    vec_t t;
    t.rst = r; t.ready = rdy; t.exp_valid = v; t.exp_op = op;
    t.exp_pc = pc; t.exp_req = rq; t.exp_addr = ad;
    vecs.push_back(t);
  endtask

  initial begin
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Zero-wait streaming: lw, sw, then filler words.
    add(1, 1, 0, 6'h00, 32'h0, 1, 32'h0);
    add(0, 1, 1, 6'h23, 32'h0, 1, 32'h4);
    add(0, 1, 1, 6'h2B, 32'h4, 1, 32'h8);
    add(0, 1, 1, 6'h04, 32'h8, 1, 32'hC);
    // Back-pressure: two entries buffer, request drops, resume at 8.
    add(1, 0, 0, 6'h00, 32'h0, 1, 32'h0);
    add(0, 0, 1, 6'h23, 32'h0, 1, 32'h4);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 6'h23, 32'h0, 0, 32'h8);
    add(0, 1, 1, 6'h23, 32'h0, 1, 32'h8);
    add(0, 1, 1, 6'h2B, 32'h4, 1, 32'hC);
    add(0, 1, 1, 6'h04, 32'h8, 1, 32'h10);
    add(0, 1, 1, 6'h04, 32'hC, 1, 32'h14);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      else @(negedge clk);
      instr_ready = vecs[i].ready;
      #1;
      chk($sformatf("v%0d valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d opcode", i), {26'b0, opcode}, {26'b0, vecs[i].exp_op});
      chk($sformatf("v%0d pc", i), instr_pc, vecs[i].exp_pc);
      chk($sformatf("v%0d req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      chk($sformatf("v%0d addr", i), imem_addr, vecs[i].exp_addr);
    end

    // Delayed memory with redirect during the wait.
    do_reset(); delay = 3; instr_ready = 1'b1;
    #1 chk("t3 c0 addr", imem_addr, 32'h0);
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h100;
    #1 chk("t3 c1 req", {31'b0, imem_req}, 32'h1);
    @(negedge clk); redirect = 1'b0;
    #1 chk("t3 c2 addr", imem_addr, 32'h0);
    chk("t3 c2 req", {31'b0, imem_req}, 32'h1);
    @(negedge clk);
    #1 chk("t3 c3 addr", imem_addr, 32'h0);
    chk("t3 c3 valid", {31'b0, instr_valid}, 32'h0);
    @(negedge clk);
    #1 chk("t3 c4 addr", imem_addr, 32'h100);
    chk("t3 c4 valid", {31'b0, instr_valid}, 32'h0);
    repeat (3) @(negedge clk);
    #1 chk("t3 c7 valid", {31'b0, instr_valid}, 32'h0);
    @(negedge clk);
    #1 chk("t3 c8 valid", {31'b0, instr_valid}, 32'h1);
    chk("t3 c8 pc", instr_pc, 32'h100);
    chk("t3 c8 word", instr_word, 32'h1000_0100);

    // Redirect together with head handshake and ack.
    do_reset(); delay = 0; instr_ready = 1'b1;
    #1 chk("t4 c0 valid", {31'b0, instr_valid}, 32'h0);
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h200;
    #1 chk("t4 c1 valid", {31'b0, instr_valid}, 32'h1);
    chk("t4 c1 pc", instr_pc, 32'h0);
    chk("t4 c1 addr", imem_addr, 32'h4);
    @(negedge clk); redirect = 1'b0;
    #1 chk("t4 c2 valid", {31'b0, instr_valid}, 32'h0);
    chk("t4 c2 addr", imem_addr, 32'h200);
    @(negedge clk);
    #1 chk("t4 c3 valid", {31'b0, instr_valid}, 32'h1);
    chk("t4 c3 pc", instr_pc, 32'h200);

    // Reset PC at top of address space wraps.
    do_reset();
    #1 chk("t5 c0 addr", addr5, 32'hFFFF_FFFC);
    @(negedge clk);
    #1 chk("t5 c1 addr", addr5, 32'h0);
    chk("t5 c1 pc", pc5, 32'hFFFF_FFFC);
    chk("t5 c1 valid", {31'b0, valid5}, 32'h1);

    // Misaligned redirect, then async reset mid-wait.
    do_reset(); delay = 0; instr_ready = 1'b1;
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h103;
    #1 chk("t6 c1 mis", {31'b0, misalign_err}, 32'h0);
    @(negedge clk); redirect = 1'b0;
    #1 chk("t6 c2 mis", {31'b0, misalign_err}, 32'h1);
    chk("t6 c2 addr", imem_addr, 32'h100);
    @(negedge clk); delay = 3;
    #1 chk("t6 c3 pc", instr_pc, 32'h100);
    chk("t6 c3 addr", imem_addr, 32'h104);
    @(negedge clk);
    #1 chk("t6 c4 mis", {31'b0, misalign_err}, 32'h1);
    chk("t6 c4 req", {31'b0, imem_req}, 32'h1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("t6 rst req", {31'b0, imem_req}, 32'h0);
    chk("t6 rst valid", {31'b0, instr_valid}, 32'h0);
    chk("t6 rst word", instr_word, 32'h0);
    chk("t6 rst pc", instr_pc, 32'h0);
    chk("t6 rst op", {26'b0, opcode}, 32'h0);
    chk("t6 rst mis", {31'b0, misalign_err}, 32'h0);
    chk("t6 rst addr", imem_addr, 32'h0);
    @(negedge clk); reset = 1'b0; delay = 0;
    #1 chk("t6 r0 req", {31'b0, imem_req}, 32'h1);
    chk("t6 r0 addr", imem_addr, 32'h0);
    @(negedge clk);
    #1 chk("t6 r1 op", {26'b0, opcode}, 32'h23);
    chk("t6 r1 mis", {31'b0, misalign_err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
